// File: rtl/pipe_mips32.sv
// pipe_mips32 -- five-stage (IF/ID/EX/MEM/WB) in-order MIPS32-subset core.
// A single unified word-addressed memory (Mem) holds instructions and data.
// The 32x32 register bank (Reg_bank) is also internal to this module.
// Operands are forwarded into EX, so programs need no software NOPs.
// A load followed immediately by a consumer of its result costs one
// interlock cycle.
// Ports:
//   clk1    in   sole clock, all state updates on the rising edge
//   rst     in   synchronous active-high reset (Reg_bank/Mem are kept)
//   halted  out  1 once HLT has retired; the core is frozen until rst
module pipe_mips32 #(
    parameter int MEM_WORDS = 1024
) (
    input  logic clk1,
    input  logic rst,
    output logic halted
);
    localparam int AW = $clog2(MEM_WORDS);

    localparam logic [5:0] OP_ADD   = 6'h00;
    localparam logic [5:0] OP_SUB   = 6'h01;
    localparam logic [5:0] OP_AND   = 6'h02;
    localparam logic [5:0] OP_OR    = 6'h03;
    localparam logic [5:0] OP_SLT   = 6'h04;
    localparam logic [5:0] OP_MUL   = 6'h05;
    localparam logic [5:0] OP_LW    = 6'h08;
    localparam logic [5:0] OP_SW    = 6'h09;
    localparam logic [5:0] OP_ADDI  = 6'h0A;
    localparam logic [5:0] OP_SUBI  = 6'h0B;
    localparam logic [5:0] OP_SLTI  = 6'h0C;
    localparam logic [5:0] OP_BNEQZ = 6'h0D;
    localparam logic [5:0] OP_BEQZ  = 6'h0E;
    localparam logic [5:0] OP_HLT   = 6'h3F;

    logic [31:0]   Reg_bank [0:31];
    logic [31:0]   Mem [0:MEM_WORDS-1];
    logic [AW-1:0] PC;
    logic          HALTED;
    logic          TAKEN_BRANCH;
    logic          fetch_stop;

    // IF/ID
    logic          if_id_valid;
    logic [31:0]   if_id_ir;
    logic [AW-1:0] if_id_npc;

    // ID/EX (a bubble has every control flag low)
    logic [5:0]    id_ex_op;
    logic [4:0]    id_ex_rs, id_ex_rt, id_ex_dest;
    logic [31:0]   id_ex_a, id_ex_b, id_ex_imm;
    logic [AW-1:0] id_ex_npc;
    logic          id_ex_wr, id_ex_load, id_ex_store, id_ex_branch, id_ex_hlt;

    // EX/MEM
    logic [4:0]    ex_mem_dest;
    logic [31:0]   ex_mem_alu, ex_mem_sdata;
    logic          ex_mem_wr, ex_mem_load, ex_mem_store, ex_mem_hlt;

    // MEM/WB
    logic [4:0]    mem_wb_dest;
    logic [31:0]   mem_wb_val;
    logic          mem_wb_wr, mem_wb_hlt;

    assign halted = HALTED;

    // ---------------- ID: decode, register read, hazard detect ----------
    logic [5:0]  id_op;
    logic [4:0]  id_rs, id_rt, id_rd, id_dest;
    logic [31:0] id_imm, id_a, id_b;
    logic        id_rr, id_ri, id_lw, id_sw, id_br, id_hlt;
    logic        id_wr, id_uses_rs, id_uses_rt, stall;

    assign id_op  = if_id_ir[31:26];
    assign id_rs  = if_id_ir[25:21];
    assign id_rt  = if_id_ir[20:16];
    assign id_rd  = if_id_ir[15:11];
    assign id_imm = {{16{if_id_ir[15]}}, if_id_ir[15:0]};

    always_comb begin
        id_rr  = 1'b0;
        id_ri  = 1'b0;
        id_lw  = 1'b0;
        id_sw  = 1'b0;
        id_br  = 1'b0;
        id_hlt = 1'b0;
        if (if_id_valid) begin
            case (id_op)
                OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_MUL: id_rr = 1'b1;
                OP_ADDI, OP_SUBI, OP_SLTI:                     id_ri = 1'b1;
                OP_LW:                                         id_lw = 1'b1;
                OP_SW:                                         id_sw = 1'b1;
                OP_BNEQZ, OP_BEQZ:                             id_br = 1'b1;
                OP_HLT:                                        id_hlt = 1'b1;
                default: ;
            endcase
        end
    end

    assign id_wr      = id_rr | id_ri | id_lw;
    assign id_dest    = id_rr ? id_rd : id_rt;
    assign id_uses_rs = id_rr | id_ri | id_lw | id_sw | id_br;
    assign id_uses_rt = id_rr | id_sw;

    // Write-before-read: a value retiring in WB this cycle is visible in ID.
    always_comb begin
        id_a = '0;
        id_b = '0;
        if (id_rs != 5'd0)
            id_a = (mem_wb_wr && mem_wb_dest == id_rs) ? mem_wb_val : Reg_bank[id_rs];
        if (id_rt != 5'd0)
            id_b = (mem_wb_wr && mem_wb_dest == id_rt) ? mem_wb_val : Reg_bank[id_rt];
    end

    // A load in EX has no data until MEM, so its consumer waits one cycle.
    assign stall = id_ex_load && (id_ex_dest != 5'd0) &&
                   ((id_uses_rs && id_rs == id_ex_dest) ||
                    (id_uses_rt && id_rt == id_ex_dest));

    // ---------------- EX: forwarding, ALU, branch resolve ---------------
    logic [31:0]   ex_a, ex_b, ex_alu;
    logic          br_taken;
    logic [AW-1:0] br_target;

    // EX/MEM has priority over MEM/WB; a load in EX/MEM never forwards
    // (the interlock keeps its consumer out of EX for that cycle).
    always_comb begin
        ex_a = id_ex_a;
        ex_b = id_ex_b;
        if (ex_mem_wr && !ex_mem_load && ex_mem_dest != 5'd0 && ex_mem_dest == id_ex_rs)
            ex_a = ex_mem_alu;
        else if (mem_wb_wr && mem_wb_dest != 5'd0 && mem_wb_dest == id_ex_rs)
            ex_a = mem_wb_val;
        if (ex_mem_wr && !ex_mem_load && ex_mem_dest != 5'd0 && ex_mem_dest == id_ex_rt)
            ex_b = ex_mem_alu;
        else if (mem_wb_wr && mem_wb_dest != 5'd0 && mem_wb_dest == id_ex_rt)
            ex_b = mem_wb_val;
    end

    always_comb begin
        case (id_ex_op)
            OP_ADD:               ex_alu = ex_a + ex_b;
            OP_SUB:               ex_alu = ex_a - ex_b;
            OP_AND:               ex_alu = ex_a & ex_b;
            OP_OR:                ex_alu = ex_a | ex_b;
            OP_SLT:               ex_alu = {31'd0, $signed(ex_a) < $signed(ex_b)};
            OP_MUL:               ex_alu = ex_a * ex_b;
            OP_ADDI, OP_LW, OP_SW: ex_alu = ex_a + id_ex_imm;
            OP_SUBI:              ex_alu = ex_a - id_ex_imm;
            OP_SLTI:              ex_alu = {31'd0, $signed(ex_a) < $signed(id_ex_imm)};
            default:              ex_alu = '0;
        endcase
    end

    assign br_taken  = id_ex_branch &&
                       ((id_ex_op == OP_BNEQZ) ? (ex_a != 32'd0) : (ex_a == 32'd0));
    assign br_target = id_ex_npc + id_ex_imm[AW-1:0];

    // ---------------- MEM ------------------------------------------------
    logic [31:0] mem_result;
    assign mem_result = ex_mem_load ? Mem[ex_mem_alu[AW-1:0]] : ex_mem_alu;

    // ---------------- pipeline registers --------------------------------
    always_ff @(posedge clk1) begin
        if (rst) begin
            PC           <= '0;
            HALTED       <= 1'b0;
            TAKEN_BRANCH <= 1'b0;
            fetch_stop   <= 1'b0;
            if_id_valid  <= 1'b0;
            id_ex_wr     <= 1'b0;
            id_ex_load   <= 1'b0;
            id_ex_store  <= 1'b0;
            id_ex_branch <= 1'b0;
            id_ex_hlt    <= 1'b0;
            ex_mem_wr    <= 1'b0;
            ex_mem_load  <= 1'b0;
            ex_mem_store <= 1'b0;
            ex_mem_hlt   <= 1'b0;
            mem_wb_wr    <= 1'b0;
            mem_wb_hlt   <= 1'b0;
        end else if (!HALTED) begin
            TAKEN_BRANCH <= br_taken;
            if (mem_wb_hlt)
                HALTED <= 1'b1;

            mem_wb_wr    <= ex_mem_wr;
            mem_wb_hlt   <= ex_mem_hlt;
            mem_wb_dest  <= ex_mem_dest;
            mem_wb_val   <= mem_result;

            ex_mem_wr    <= id_ex_wr;
            ex_mem_load  <= id_ex_load;
            ex_mem_store <= id_ex_store;
            ex_mem_hlt   <= id_ex_hlt;
            ex_mem_dest  <= id_ex_dest;
            ex_mem_alu   <= ex_alu;
            ex_mem_sdata <= ex_b;

            if (br_taken) begin
                // Flush the two younger stages; this also cancels a pending HLT.
                PC           <= br_target;
                fetch_stop   <= 1'b0;
                if_id_valid  <= 1'b0;
                id_ex_wr     <= 1'b0;
                id_ex_load   <= 1'b0;
                id_ex_store  <= 1'b0;
                id_ex_branch <= 1'b0;
                id_ex_hlt    <= 1'b0;
            end else if (stall) begin
                id_ex_wr     <= 1'b0;
                id_ex_load   <= 1'b0;
                id_ex_store  <= 1'b0;
                id_ex_branch <= 1'b0;
                id_ex_hlt    <= 1'b0;
            end else begin
                id_ex_op     <= id_op;
                id_ex_rs     <= id_rs;
                id_ex_rt     <= id_rt;
                id_ex_dest   <= id_dest;
                id_ex_a      <= id_a;
                id_ex_b      <= id_b;
                id_ex_imm    <= id_imm;
                id_ex_npc    <= if_id_npc;
                id_ex_wr     <= id_wr;
                id_ex_load   <= id_lw;
                id_ex_store  <= id_sw;
                id_ex_branch <= id_br;
                id_ex_hlt    <= id_hlt;
                if (id_hlt || fetch_stop) begin
                    fetch_stop  <= 1'b1;
                    if_id_valid <= 1'b0;
                end else begin
                    if_id_valid <= 1'b1;
                    if_id_ir    <= Mem[PC];
                    if_id_npc   <= PC + AW'(1);
                    PC          <= PC + AW'(1);
                end
            end
        end
    end

    // Architectural storage is not cleared by reset.
    always_ff @(posedge clk1) begin
        if (!rst && !HALTED) begin
            if (mem_wb_wr && mem_wb_dest != 5'd0)
                Reg_bank[mem_wb_dest] <= mem_wb_val;
            if (ex_mem_store)
                Mem[ex_mem_alu[AW-1:0]] <= ex_mem_sdata;
        end
    end
endmodule

// File: tb/tb_pipe_mips32.sv
// tb_pipe_mips32 -- scoreboard bench for pipe_mips32.
// Each program is run through a sequential instruction-set interpreter;
// its final registers, memory, halt cycle and taken-branch count are queued.
// A monitor pops and compares them when halted rises.
module tb_pipe_mips32;
    localparam int MW = 1024;

    logic clk1 = 1'b0;
    logic rst  = 1'b1;
    logic halted;

    always #5 clk1 = ~clk1;

    pipe_mips32 #(.MEM_WORDS(MW)) dut (
        .clk1   (clk1),
        .rst    (rst),
        .halted (halted)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int edge_cnt = 0;
    int taken_cnt = 0;
    logic prev_halted = 1'b0;

    logic [31:0] exp_words [$];
    int          exp_cycles [$];
    int          exp_taken [$];

    logic [31:0] prog [$];
    logic [31:0] init_regs [32];
    logic [31:0] init_mem [MW];
    logic [31:0] m_regs [32];
    logic [31:0] m_mem [MW];

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d] got %h expected %h", name, idx, act, exp);
        end
    endtask

    function automatic logic [31:0] enc_r(input int op, input int rs, input int rt, input int rd);
        return {op[5:0], rs[4:0], rt[4:0], rd[4:0], 11'd0};
    endfunction

    function automatic logic [31:0] enc_i(input int op, input int rs, input int rt, input int imm);
        return {op[5:0], rs[4:0], rt[4:0], imm[15:0]};
    endfunction

    // Cycle counter: edge_cnt = number of rising edges since rst fell.
    always @(posedge clk1) begin
        if (rst) edge_cnt = 0;
        else     edge_cnt++;
    end

    // Monitor / scoreboard.
    always @(negedge clk1) begin
        if (rst) taken_cnt = 0;
        else if (dut.TAKEN_BRANCH === 1'b1) taken_cnt++;
        if (!rst && halted === 1'b1 && !prev_halted) begin
            if (exp_cycles.size() == 0) begin
                chk("unexpected_halt", 0, 32'd1, 32'd0);
            end else begin
                chk("halt_cycle", 0, edge_cnt, exp_cycles.pop_front());
                chk("taken_pulses", 0, taken_cnt, exp_taken.pop_front());
                for (int i = 1; i < 32; i++) chk("reg", i, dut.Reg_bank[i], exp_words.pop_front());
                for (int i = 0; i < MW; i++) chk("mem", i, dut.Mem[i], exp_words.pop_front());
            end
        end
        prev_halted = (halted === 1'b1);
    end

    // Sequential reference: one instruction per step, plus cycle accounting
    // (5-edge fill, +1 per load-use pair, +2 per taken branch).
    task automatic model_run(output int cycles, output int taken);
        int pc, d, stalls, tk, nxt;
        logic prev_lw;
        logic [4:0] prev_dest, rs, rt, rd;
        logic [5:0] op;
        logic [31:0] ir, a, b, imm, t;
        logic urs, urt;
        pc = 0; d = 0; stalls = 0; tk = 0; prev_lw = 1'b0; prev_dest = '0;
        for (int i = 0; i < 32; i++) m_regs[i] = init_regs[i];
        m_regs[0] = '0;
        for (int i = 0; i < MW; i++) m_mem[i] = init_mem[i];
        for (int step = 0; step < 4000; step++) begin
            ir = m_mem[pc];
            op = ir[31:26]; rs = ir[25:21]; rt = ir[20:16]; rd = ir[15:11];
            imm = {{16{ir[15]}}, ir[15:0]};
            urs = (op <= 6'h05) || (op >= 6'h08 && op <= 6'h0E);
            urt = (op <= 6'h05) || (op == 6'h09);
            if (prev_lw && prev_dest != 0 && ((urs && rs == prev_dest) || (urt && rt == prev_dest)))
                stalls++;
            if (op == 6'h3F) break;
            a = (rs == 0) ? 32'd0 : m_regs[rs];
            b = (rt == 0) ? 32'd0 : m_regs[rt];
            nxt = (pc + 1) % MW;
            case (op)
                6'h00: if (rd != 0) m_regs[rd] = a + b;
                6'h01: if (rd != 0) m_regs[rd] = a - b;
                6'h02: if (rd != 0) m_regs[rd] = a & b;
                6'h03: if (rd != 0) m_regs[rd] = a | b;
                6'h04: if (rd != 0) m_regs[rd] = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                6'h05: if (rd != 0) m_regs[rd] = a * b;
                6'h0A: if (rt != 0) m_regs[rt] = a + imm;
                6'h0B: if (rt != 0) m_regs[rt] = a - imm;
                6'h0C: if (rt != 0) m_regs[rt] = ($signed(a) < $signed(imm)) ? 32'd1 : 32'd0;
                6'h08: begin t = (a + imm) % MW; if (rt != 0) m_regs[rt] = m_mem[t]; end
                6'h09: begin t = (a + imm) % MW; m_mem[t] = b; end
                6'h0D, 6'h0E: begin
                    if ((op == 6'h0D) ? (a != 0) : (a == 0)) begin
                        t = pc + 1 + imm;
                        nxt = t % MW;
                        tk++;
                    end
                end
                default: ;
            endcase
            prev_lw = (op == 6'h08);
            prev_dest = rt;
            pc = nxt;
            d++;
        end
        cycles = d + 5 + stalls + 2 * tk;
        taken = tk;
    endtask

    // Load prog/init_regs/init_mem into the DUT, queue expectations, run.
    task automatic run_program(input bit glitch);
        int cyc, tk;
        bit seen;
        for (int i = 0; i < prog.size(); i++) init_mem[i] = prog[i];
        rst = 1'b1;
        @(negedge clk1);
        for (int i = 0; i < MW; i++) dut.Mem[i] = init_mem[i];
        for (int i = 0; i < 32; i++) dut.Reg_bank[i] = init_regs[i];
        model_run(cyc, tk);
        exp_cycles.push_back(cyc);
        exp_taken.push_back(tk);
        for (int i = 1; i < 32; i++) exp_words.push_back(m_regs[i]);
        for (int i = 0; i < MW; i++) exp_words.push_back(m_mem[i]);
        @(negedge clk1);
        chk("reset_halted", 0, halted, 1'b0);
        chk("reset_pc", 0, 32'(dut.PC), 32'd0);
        chk("reset_taken", 0, dut.TAKEN_BRANCH, 1'b0);
        rst = 1'b0;
        if (glitch) begin
            repeat (3) @(negedge clk1);
            rst = 1'b1;
            @(negedge clk1);
            chk("glitch_pc", 0, 32'(dut.PC), 32'd0);
            chk("glitch_halted", 0, halted, 1'b0);
            chk("glitch_r1_unwritten", 1, dut.Reg_bank[1], init_regs[1]);
            rst = 1'b0;
        end
        seen = 1'b0;
        for (int c = 0; c < 3000 && !seen; c++) begin
            @(negedge clk1);
            if (halted === 1'b1) seen = 1'b1;
        end
        if (!seen) begin
            chk("halt_timeout", 0, 32'd0, 32'd1);
            void'(exp_cycles.pop_back());
            void'(exp_taken.pop_back());
            repeat (31 + MW) void'(exp_words.pop_back());
        end
        repeat (2) @(negedge clk1);
    endtask

    task automatic clear_setup(input bit identity_regs);
        prog.delete();
        for (int i = 0; i < MW; i++) init_mem[i] = '0;
        for (int i = 0; i < 32; i++) init_regs[i] = identity_regs ? 32'(i) : 32'd0;
    endtask

    initial begin
        // Reference program with Reg_bank[k] = k.
        clear_setup(1'b1);
        prog = '{32'h2801000a, 32'h28020014, 32'h28030019, 32'h0ce77800, 32'h0ce77800,
                 32'h00222000, 32'h0ce77800, 32'h00832800, 32'hfc000000};
        run_program(1'b0);

        // Back-to-back RAW, no stalls.
        clear_setup(1'b0);
        prog = '{enc_i(8'h0A, 0, 1, 10), enc_r(0, 1, 1, 2), enc_r(0, 2, 1, 3), 32'hfc000000};
        run_program(1'b0);

        // Load-use interlock.
        clear_setup(1'b0);
        init_mem[120] = 32'd85;
        prog = '{enc_i(8'h08, 0, 2, 120), enc_r(0, 2, 2, 3), 32'hfc000000};
        run_program(1'b0);

        // Store then load.
        clear_setup(1'b0);
        init_regs[1] = 32'd10;
        prog = '{enc_i(8'h09, 0, 1, 100), enc_i(8'h08, 0, 4, 100), 32'hfc000000};
        run_program(1'b0);

        // Countdown loop; R6 increment sits behind the branch.
        clear_setup(1'b1);
        prog = '{enc_i(8'h0A, 0, 1, 3), enc_i(8'h0A, 1, 1, -1), enc_i(8'h0D, 1, 0, -2),
                 enc_i(8'h0A, 6, 6, 1), 32'hfc000000};
        run_program(1'b0);

        // Taken branch over a HLT that is already in the pipe.
        clear_setup(1'b1);
        prog = '{enc_i(8'h0E, 0, 0, 1), 32'hfc000000, enc_i(8'h0A, 0, 7, 77), 32'hfc000000};
        run_program(1'b0);

        // Writes to R0 are discarded.
        clear_setup(1'b0);
        prog = '{enc_i(8'h0A, 0, 0, 5), enc_r(0, 0, 0, 1), 32'hfc000000};
        run_program(1'b0);

        // Reset while the pipeline is full, then rerun.
        clear_setup(1'b1);
        prog = '{enc_i(8'h0A, 1, 1, 1), enc_i(8'h0A, 1, 1, 1), enc_i(8'h0A, 1, 1, 1),
                 enc_i(8'h0A, 1, 1, 1), enc_i(8'h09, 0, 1, 600), 32'hfc000000};
        run_program(1'b1);

        // Random programs: forward-only branches, loads/stores in 512..575.
        for (int p = 0; p < 8; p++) begin
            clear_setup(1'b0);
            init_regs[0] = $urandom;
            for (int i = 1; i < 32; i++)
                init_regs[i] = ($urandom_range(0, 3) == 0) ? 32'd0 : ($urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 20)));
            for (int i = 512; i < 576; i++) init_mem[i] = $urandom;
            for (int i = 0; i < 16; i++) begin
                int k;
                k = $urandom_range(0, 9);
                if (k <= 3)
                    prog.push_back(enc_r($urandom_range(0, 5), $urandom_range(0, 7),
                                         $urandom_range(0, 7), $urandom_range(0, 7)));
                else if (k <= 5)
                    prog.push_back(enc_i($urandom_range(10, 12), $urandom_range(0, 7),
                                         $urandom_range(0, 7), $urandom_range(0, 65535)));
                else if (k == 6)
                    prog.push_back(enc_i(8'h08, 0, $urandom_range(0, 7), 512 + $urandom_range(0, 63)));
                else if (k == 7)
                    prog.push_back(enc_i(8'h09, 0, $urandom_range(0, 7), 512 + $urandom_range(0, 63)));
                else
                    prog.push_back(enc_i($urandom_range(13, 14), $urandom_range(0, 7), 0,
                                         $urandom_range(0, 3)));
            end
            repeat (8) prog.push_back(32'hfc000000);
            run_program(1'b0);
        end

        chk("queue_drained", 0, exp_cycles.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
